// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - shared memory port bus between the arbiter and the memory
//
// Ports (grouped signals):
//   bus_req   arbiter -> memory  access active
//   bus_we    arbiter -> memory  write strobe
//   bus_addr  arbiter -> memory  word address, [1:0] = 0
//   bus_be    arbiter -> memory  byte enables
//   bus_wdata arbiter -> memory  lane-aligned write data
//   bus_ready memory -> arbiter  access complete this cycle
//   bus_rdata memory -> arbiter  read word, valid with bus_ready
interface mem_port_arbiter_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ready;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_ready, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_ready, bus_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - IF/MEM arbiter and sequencer for one shared memory port
//
// Ports:
//   clock, reset_n              rising-edge clock, asynchronous active-low reset
//   if_req/if_addr              fetch request and byte address
//   if_valid/if_rdata           fetch retired pulse and fetched word
//   mem_req/we/sb/lh/addr/wdata MEM-stage command from EX/MEM
//   mem_done/mem_rdata/mem_err  MEM retired pulse, load result, timeout flag
//   stall_if, stall_mem         combinational stalls back to the pipeline
//   halt_in, halted             halt request and parked indication
//   bus                         memory-side port (master modport)
module mem_port_arbiter #(
    parameter int TIMEOUT = 64
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       if_req,
    input  logic [31:0]                if_addr,
    output logic                       if_valid,
    output logic [31:0]                if_rdata,
    input  logic                       mem_req,
    input  logic                       mem_we,
    input  logic                       mem_sb,
    input  logic                       mem_lh,
    input  logic [31:0]                mem_addr,
    input  logic [31:0]                mem_wdata,
    output logic                       mem_done,
    output logic [31:0]                mem_rdata,
    output logic                       mem_err,
    output logic                       stall_if,
    output logic                       stall_mem,
    input  logic                       halt_in,
    output logic                       halted,
    mem_port_arbiter_if.master         bus
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        IF_WAIT  = 2'd1,
        MEM_WAIT = 2'd2,
        HALTED   = 2'd3
    } state_t;

    state_t state, state_next;

    logic grant_mem, grant_if, finish, abort;
    logic [CW-1:0] wd;
    logic cmd_load, cmd_lh, cmd_hi;
    logic [31:0] ld_value;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // During the done/valid pulse cycle the requester still holds its old
    // request, so that request is masked to avoid issuing it a second time.
    always_comb begin
        state_next = state;
        grant_mem  = 1'b0;
        grant_if   = 1'b0;
        finish     = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: begin
                if (mem_req && !mem_done) begin
                    grant_mem  = 1'b1;
                    state_next = MEM_WAIT;
                end else if (halt_in) begin
                    state_next = HALTED;
                end else if (if_req && !if_valid) begin
                    grant_if   = 1'b1;
                    state_next = IF_WAIT;
                end
            end
            IF_WAIT, MEM_WAIT: begin
                if (bus.bus_ready) begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end else if (wd == WD_LAST) begin
                    abort      = 1'b1;
                    state_next = IDLE;
                end
            end
            HALTED: state_next = HALTED;
            default: state_next = IDLE;
        endcase
    end

    // Halfword select uses addr[1] only; addr[0] is ignored by design.
    always_comb begin
        ld_value = bus.bus_rdata;
        if (cmd_lh) begin
            if (cmd_hi) begin
                ld_value = {{16{bus.bus_rdata[31]}}, bus.bus_rdata[31:16]};
            end else begin
                ld_value = {{16{bus.bus_rdata[15]}}, bus.bus_rdata[15:0]};
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bus.bus_we    <= 1'b0;
            bus.bus_addr  <= '0;
            bus.bus_be    <= '0;
            bus.bus_wdata <= '0;
            cmd_load      <= 1'b0;
            cmd_lh        <= 1'b0;
            cmd_hi        <= 1'b0;
            wd            <= '0;
            if_valid      <= 1'b0;
            if_rdata      <= '0;
            mem_done      <= 1'b0;
            mem_rdata     <= '0;
            mem_err       <= 1'b0;
        end else begin
            if_valid <= 1'b0;
            mem_done <= 1'b0;
            mem_err  <= 1'b0;

            if (grant_mem) begin
                bus.bus_addr <= mem_addr & 32'hFFFF_FFFC;
                bus.bus_we   <= mem_we;
                cmd_load     <= ~mem_we;
                cmd_lh       <= mem_lh & ~mem_we;
                cmd_hi       <= mem_addr[1];
                wd           <= '0;
                if (mem_we && mem_sb) begin
                    bus.bus_be    <= 4'b0001 << mem_addr[1:0];
                    bus.bus_wdata <= {4{mem_wdata[7:0]}};
                end else begin
                    bus.bus_be    <= 4'b1111;
                    bus.bus_wdata <= mem_wdata;
                end
            end else if (grant_if) begin
                bus.bus_addr  <= if_addr & 32'hFFFF_FFFC;
                bus.bus_we    <= 1'b0;
                bus.bus_be    <= 4'b1111;
                bus.bus_wdata <= '0;
                wd            <= '0;
            end else if (bus.bus_req && !bus.bus_ready) begin
                wd <= wd + 1'b1;
            end

            if (state == IF_WAIT && (finish || abort)) begin
                if_valid <= 1'b1;
                if_rdata <= finish ? bus.bus_rdata : NOP_INSN;
            end

            if (state == MEM_WAIT) begin
                if (finish) begin
                    mem_done <= 1'b1;
                    if (cmd_load) begin
                        mem_rdata <= ld_value;
                    end
                end else if (abort) begin
                    mem_done  <= 1'b1;
                    mem_err   <= 1'b1;
                    mem_rdata <= '0;
                end
            end
        end
    end

    // bus_req comes straight from the state register, so an asynchronous
    // reset drops it immediately and discards the in-flight access.
    assign bus.bus_req = (state == IF_WAIT) || (state == MEM_WAIT);
    assign halted      = (state == HALTED);
    assign stall_if    = if_req & ~if_valid;
    assign stall_mem   = mem_req & ~mem_done;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencer and arbiter for the single shared memory port between instruction fetch (IF) and the MEM stage fed by the EX/MEM pipeline register. It grants one requester at a time, with MEM having priority. It drives a ready/valid-style bus with byte enables derived from the store-byte and load-half controls, and returns stall signals to the pipeline. It also drains and parks the port when the pipeline signals halt.

## Interface
- TIMEOUT, 64: bus wait cycles before an access is aborted; must be ≥2.
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request
- if_addr  in  32  fetch byte address
- if_valid  out  1  one-cycle pulse: if_rdata valid, fetch retired
- if_rdata  out  32  fetched word
- mem_req  in  1  MEM access request (memWrite | memtoReg from EX/MEM)
- mem_we  in  1  1 = store
- mem_sb  in  1  store byte
- mem_lh  in  1  load halfword, sign-extended
- mem_addr  in  32  ALUresult
- mem_wdata  in  32  readData2
- mem_done  out  1  one-cycle pulse: MEM access retired
- mem_rdata  out  32  load result, aligned and extended
- mem_err  out  1  one-cycle pulse with mem_done on timeout
- stall_if, stall_mem  out  1  combinational: req & ~valid/done
- halt_in  in  1  halt from EX/MEM
- halted  out  1  port parked
- bus_req  out  1  access active
- bus_we  out  1  write strobe
- bus_addr  out  32  word address, [1:0] = 0
- bus_be  out  4  byte enables
- bus_wdata  out  32  lane-aligned write data
- bus_ready  in  1  access complete this cycle
- bus_rdata  in  32  read word, valid with bus_ready

## Operation
- States: IDLE, IF_WAIT, MEM_WAIT, HALTED.
- IDLE transitions, in priority order:
  - mem_req → latch MEM command, go MEM_WAIT.
  - else halt_in → HALTED.
  - else if_req → latch if_addr, go IF_WAIT.
  - else stay.
- Both WAIT states assert bus_req, driven from registers only.
- bus_ready in a WAIT state → capture data, pulse if_valid or mem_done, return to IDLE.
- Watchdog counter clears on entry to a WAIT state and increments each cycle without bus_ready.
  - Reaching TIMEOUT-1 → abort to IDLE with a done pulse and rdata = 0.
  - mem_err pulses on MEM aborts only. IF aborts assert if_valid with if_rdata = 0x00000013 (NOP).
- Store byte enables and data:
  - Word store: bus_be = 1111, bus_wdata = mem_wdata.
  - sb: bus_be = 0001 << addr[1:0], bus_wdata = byte[7:0] replicated ×4.
  - Store half (not sb, not lh): treated as a word store. Halfword stores do not exist in this ISA subset.
- Loads:
  - bus_be = 1111, bus_we = 0.
  - lh: mem_rdata = sign-extended halfword selected by addr[1]. addr[0] is ignored, no alignment trap.
  - Word load: full word. addr[1:0] are ignored.
- HALTED is terminal until reset. No grants are issued and if_req is ignored, so stall_if stays high. halted = 1.
- mem_req arriving while in IF_WAIT waits for the fetch to finish; it is never preempted.

## Timing
- Reset (async, immediate) sets all outputs and registers to 0: state IDLE, bus_req = 0, halted = 0, counter = 0.
- Request seen in IDLE at edge N → bus_req = 1 from N+1.
- Zero-wait bus (bus_ready at N+1) → done/valid pulse and rdata at N+2. Minimum latency is 2 cycles; one access per 2 cycles.
- rdata outputs hold their value until the next capture.
- Pulses last exactly one cycle.
- The requester holds req and its command stable until it sees done/valid. The block only latches at grant.
- Simultaneous mem_req and if_req → MEM first. IF is granted on the next IDLE cycle.
- Simultaneous mem_req and halt_in → MEM first, then HALTED.
- reset_n low mid-access drops bus_req asynchronously. The in-flight access is discarded with no pulse.

## Test plan
- Reset: hold reset_n = 0 mid-MEM_WAIT → bus_req, halted, and all pulses read 0 immediately. IF fetch of 0x100 completes after release.
- Arbitration: if_req and mem_req (load from 0x20) both high, zero-wait bus → MEM granted first (bus_addr = 0x20). IF granted 2 cycles later. stall_if is high for 4 cycles.
- sb to 0x1003 with wdata 0xAABBCCDD → bus_addr = 0x1000, bus_be = 1000, bus_wdata = 0xDDDDDDDD, bus_we = 1.
- lh from 0x2002 with bus_rdata 0x8001_1234 → mem_rdata = 0xFFFF8001. lh from 0x2000 → 0x00001234.
- Timeout (TIMEOUT = 8): bus_ready held low on a MEM load → mem_done and mem_err pulse together. mem_rdata = 0, state returns to IDLE.
- Halt: halt_in with mem_req pending → the store completes, then halted = 1. if_req is never granted afterward, and bus_req stays 0 for 20 cycles.
